// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace monitor.
// Optional per-entry timestamp storage: COMMIT_TRACE_TIMESTAMP_EN.
package commit_trace_pkg;

  localparam int unsigned CTM_XLEN  = 32;
  localparam int unsigned CTM_CNT_W = 32;
  localparam int unsigned ARN_W     = 5;

  // Core status codes mirrored from the system definitions.
  typedef enum logic [3:0] {
    NO_ERROR           = 4'd0,
    INSTR_ACCESS_FAULT = 4'd1,
    ILLEGAL_INSTR      = 4'd2,
    LOAD_ACCESS_FAULT  = 4'd5,
    STORE_ACCESS_FAULT = 4'd7,
    HALTED_ON_WFI      = 4'd15
  } exception_code_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StHalted  = 2'd2
  } ctm_state_e;

  typedef enum logic [1:0] {
    HaltNone     = 2'd0,
    HaltCoreErr  = 2'd1,
    HaltWatchdog = 2'd2
  } halt_cause_e;

  typedef struct packed {
    logic [CTM_XLEN-1:0]  pc;
    logic [ARN_W-1:0]     arn;
    logic [CTM_XLEN-1:0]  data;
    logic                 wr_en;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [CTM_CNT_W-1:0] timestamp;
`endif
  } trace_entry_t;

  // Load access faults are reported but are not fatal to the trace.
  function automatic logic is_core_err(exception_code_e code);
    return (code != NO_ERROR) && (code != LOAD_ACCESS_FAULT);
  endfunction

endpackage

// File: rtl/commit_lane_compactor.sv
// Combinational compaction of commit lanes: popcount plus, for each output
// slot, the index of the valid lane that fills it (ascending lane order).
module commit_lane_compactor #(
  parameter  int unsigned WAYS = 2,
  localparam int unsigned LW   = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned NW   = $clog2(WAYS + 1)
) (
  input  logic [WAYS-1:0]         valid,
  output logic [NW-1:0]           count,
  output logic [WAYS-1:0][LW-1:0] slot_lane
);

  int k;

  always_comb begin
    k         = 0;
    slot_lane = '0;
    for (int i = 0; i < WAYS; i++) begin
      for (int j = 0; j < WAYS; j++) begin
        if (valid[i] && (k == j)) slot_lane[j] = LW'(i);
      end
      if (valid[i]) k = k + 1;
    end
    count = NW'(k);
  end

endmodule

// File: rtl/commit_trace_monitor.sv
// Retirement trace buffer with CPI counters, halt detection and a drain port.
// Build option COMMIT_TRACE_TIMESTAMP_EN stores the capture cycle per entry.
module commit_trace_monitor
  import commit_trace_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned XLEN       = CTM_XLEN,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned WDOG_LIMIT = 50000,
  parameter int unsigned CNT_W      = CTM_CNT_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WAYS-1:0]           commit_valid,
  input  logic [WAYS-1:0][XLEN-1:0] commit_pc,
  input  logic [WAYS-1:0][4:0]      commit_arn,
  input  logic [WAYS-1:0][XLEN-1:0] commit_data,
  input  logic [WAYS-1:0]           commit_wr_en,
  input  exception_code_e           error_status,
  input  logic                      arm,
  input  logic                      clear,
  input  logic                      wrap_mode,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [XLEN-1:0]           rd_pc,
  output logic [4:0]                rd_arn,
  output logic [XLEN-1:0]           rd_data,
  output logic                      rd_wr_en,
  output logic [CNT_W-1:0]          rd_timestamp,
  output logic [$clog2(DEPTH):0]    trace_count,
  output logic                      overflow,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          instr_count,
  output logic                      halted,
  output logic [1:0]                halt_cause
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned NW = $clog2(WAYS + 1);

  ctm_state_e  state_q;
  halt_cause_e halt_cause_q;

  // Input stage: the cycle presented on the commit port is acted on one edge later.
  logic [WAYS-1:0]           s_valid_q;
  logic [WAYS-1:0][XLEN-1:0] s_pc_q;
  logic [WAYS-1:0][4:0]      s_arn_q;
  logic [WAYS-1:0][XLEN-1:0] s_data_q;
  logic [WAYS-1:0]           s_wr_en_q;
  logic                      s_live_q;
  logic                      s_err_q;
  logic                      live_in;

  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic [CNT_W-1:0] cycle_q, instr_q, wdog_q;
  trace_entry_t     mem_q [DEPTH];

  logic [NW-1:0]           lane_cnt;
  logic [WAYS-1:0][LW-1:0] slot_lane;
  trace_entry_t            wr_entry [WAYS];
  trace_entry_t            head;

  logic             proc, pop, drop, halt_err, halt_wdog;
  int               n_lanes, n_write, rd_adv, free_slots, count_next;
  logic [CNT_W-1:0] wdog_next;
  logic [CNT_W:0]   instr_sum;

  commit_lane_compactor #(
    .WAYS (WAYS)
  ) u_compactor (
    .valid     (s_valid_q),
    .count     (lane_cnt),
    .slot_lane (slot_lane)
  );

  assign live_in = (state_q == StCapture) && !clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_valid_q <= '0;
      s_pc_q    <= '0;
      s_arn_q   <= '0;
      s_data_q  <= '0;
      s_wr_en_q <= '0;
      s_live_q  <= 1'b0;
      s_err_q   <= 1'b0;
    end else begin
      s_valid_q <= live_in ? commit_valid : '0;
      s_pc_q    <= commit_pc;
      s_arn_q   <= commit_arn;
      s_data_q  <= commit_data;
      s_wr_en_q <= commit_wr_en;
      s_live_q  <= live_in;
      s_err_q   <= live_in && is_core_err(error_status);
    end
  end

  assign proc      = s_live_q && (state_q == StCapture);
  assign halt_err  = proc && s_err_q;
  assign wdog_next = (|s_valid_q) ? '0 : ((&wdog_q) ? wdog_q : wdog_q + 1'b1);
  assign halt_wdog = proc && (wdog_next == CNT_W'(WDOG_LIMIT));
  assign instr_sum = {1'b0, instr_q} + (CNT_W + 1)'(lane_cnt);

  // Free space counts the slot being popped; a wrap overwrite of the head beats the pop.
  always_comb begin
    pop        = rd_valid && rd_ready;
    n_lanes    = proc ? int'(lane_cnt) : 0;
    free_slots = int'(DEPTH) - int'(count_q) + (pop ? 1 : 0);
    n_write    = n_lanes;
    rd_adv     = pop ? 1 : 0;
    drop       = 1'b0;
    if (n_lanes > free_slots) begin
      drop = 1'b1;
      if (wrap_mode) rd_adv = int'(count_q) + n_lanes - int'(DEPTH);
      else           n_write = free_slots;
    end
    count_next = int'(count_q) - rd_adv + n_write;
  end

  always_comb begin
    for (int j = 0; j < WAYS; j++) begin
      wr_entry[j]       = '0;
      wr_entry[j].pc    = s_pc_q[slot_lane[j]];
      wr_entry[j].arn   = s_arn_q[slot_lane[j]];
      wr_entry[j].data  = s_data_q[slot_lane[j]];
      wr_entry[j].wr_en = s_wr_en_q[slot_lane[j]];
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      wr_entry[j].timestamp = cycle_q;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int j = 0; j < WAYS; j++) begin
        if (j < n_write) mem_q[wptr_q + PW'(j)] <= wr_entry[j];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      instr_q    <= '0;
      wdog_q     <= '0;
    end else if (clear) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      instr_q    <= '0;
      wdog_q     <= '0;
    end else begin
      wptr_q  <= wptr_q + PW'(n_write);
      rptr_q  <= rptr_q + PW'(rd_adv);
      count_q <= CW'(count_next);
      if (drop) overflow_q <= 1'b1;
      if (proc) begin
        cycle_q <= (&cycle_q) ? cycle_q : cycle_q + 1'b1;
        instr_q <= instr_sum[CNT_W] ? '1 : instr_sum[CNT_W-1:0];
        wdog_q  <= wdog_next;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      halt_cause_q <= HaltNone;
    end else if (clear) begin
      state_q      <= StIdle;
      halt_cause_q <= HaltNone;
    end else begin
      case (state_q)
        StIdle: if (arm) state_q <= StCapture;
        StCapture: begin
          if (halt_err) begin
            state_q      <= StHalted;
            halt_cause_q <= HaltCoreErr;
          end else if (halt_wdog) begin
            state_q      <= StHalted;
            halt_cause_q <= HaltWatchdog;
          end
        end
        StHalted: state_q <= StHalted;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign head     = mem_q[rptr_q];
  assign rd_valid = (count_q != '0);
  assign rd_pc    = rd_valid ? head.pc : '0;
  assign rd_arn   = rd_valid ? head.arn : '0;
  assign rd_data  = rd_valid ? head.data : '0;
  assign rd_wr_en = rd_valid && head.wr_en;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  assign rd_timestamp = rd_valid ? head.timestamp : '0;
`else
  assign rd_timestamp = '0;
`endif

  assign trace_count = count_q;
  assign overflow    = overflow_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign halted      = (state_q == StHalted);
  assign halt_cause  = halt_cause_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Scoreboard bench for commit_trace_monitor (WAYS=2, DEPTH=64, WDOG_LIMIT=8).
module tb_commit_trace_monitor;
  import commit_trace_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           commit_valid;
  logic [1:0][31:0]     commit_pc;
  logic [1:0][4:0]      commit_arn;
  logic [1:0][31:0]     commit_data;
  logic [1:0]           commit_wr_en;
  exception_code_e      error_status;
  logic                 arm, clear, wrap_mode, rd_ready;
  logic                 rd_valid;
  logic [31:0]          rd_pc, rd_data;
  logic [4:0]           rd_arn;
  logic                 rd_wr_en;
  logic [31:0]          rd_timestamp;
  logic [6:0]           trace_count;
  logic                 overflow;
  logic [31:0]          cycle_count, instr_count;
  logic                 halted;
  logic [1:0]           halt_cause;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  arn;
    logic [31:0] data;
    logic        wr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  commit_trace_monitor #(
    .WAYS       (2),
    .XLEN       (32),
    .DEPTH      (64),
    .WDOG_LIMIT (8),
    .CNT_W      (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_arn   (commit_arn),
    .commit_data  (commit_data),
    .commit_wr_en (commit_wr_en),
    .error_status (error_status),
    .arm          (arm),
    .clear        (clear),
    .wrap_mode    (wrap_mode),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_pc        (rd_pc),
    .rd_arn       (rd_arn),
    .rd_data      (rd_data),
    .rd_wr_en     (rd_wr_en),
    .rd_timestamp (rd_timestamp),
    .trace_count  (trace_count),
    .overflow     (overflow),
    .cycle_count  (cycle_count),
    .instr_count  (instr_count),
    .halted       (halted),
    .halt_cause   (halt_cause)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push_exp(input exp_t e);
    if (wrap_mode) begin
      q.push_back(e);
      if (q.size() > 64) void'(q.pop_front());
    end else if (q.size() < 64) begin
      q.push_back(e);
    end
  endtask

  // One commit cycle; lanes get distinct values derived from base.
  task automatic drive(input logic [1:0] v, input logic [31:0] base, input bit record);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      commit_pc[i]    = base + 32'(4 * i);
      commit_arn[i]   = base[6:2] + 5'(i);
      commit_data[i]  = base ^ 32'hA5A5_0000 ^ 32'(i);
      commit_wr_en[i] = base[2] ^ (i == 1);
    end
    commit_valid = v;
    if (record) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          e.pc = commit_pc[i]; e.arn = commit_arn[i];
          e.data = commit_data[i]; e.wr = commit_wr_en[i];
          push_exp(e);
        end
      end
    end
    tick();
    commit_valid = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q.delete();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    exp_t e;
    rd_ready = 1'b1;
    for (int b = 0; b < 200 && q.size() > 0; b++) begin
      if (rd_valid) begin
        e = q.pop_front();
        checks++;
        if (rd_pc !== e.pc || rd_arn !== e.arn || rd_data !== e.data || rd_wr_en !== e.wr
`ifndef COMMIT_TRACE_TIMESTAMP_EN
            || rd_timestamp !== 32'h0
`endif
           ) begin
          failures++;
          $display("FAIL %s_entry: got pc=%h arn=%0d data=%h wr=%b ts=%h, expected pc=%h arn=%0d data=%h wr=%b",
                   name, rd_pc, rd_arn, rd_data, rd_wr_en, rd_timestamp, e.pc, e.arn, e.data, e.wr);
        end
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (q.size() != 0 || rd_valid !== 1'b0 || trace_count !== 7'd0) begin
      failures++;
      $display("FAIL %s_drained: left=%0d rd_valid=%b trace_count=%0d, expected 0/0/0",
               name, q.size(), rd_valid, trace_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (rd_valid !== 1'b0 || trace_count !== 7'd0 || overflow !== 1'b0 || halted !== 1'b0 ||
        halt_cause !== 2'd0) begin
      failures++;
      $display("FAIL reset_flags: rd_valid=%b count=%0d ovf=%b halted=%b cause=%0d, expected all 0",
               rd_valid, trace_count, overflow, halted, halt_cause);
    end
    checks++;
    if (cycle_count !== 32'd0 || instr_count !== 32'd0 || rd_pc !== 32'd0 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters: cyc=%0d instr=%0d pc=%h data=%h, expected 0",
               cycle_count, instr_count, rd_pc, rd_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_compaction();
    exp_t e;
    do_clear(); wrap_mode = 1'b0;
    do_arm();
    commit_pc[1] = 32'h40; commit_arn[1] = 5'd5; commit_data[1] = 32'h7; commit_wr_en[1] = 1'b1;
    commit_pc[0] = 32'hDEAD; commit_valid = 2'b10;
    e.pc = 32'h40; e.arn = 5'd5; e.data = 32'h7; e.wr = 1'b1;
    q.push_back(e);
    tick();
    commit_valid = '0;
    tick();
    checks++;
    if (trace_count !== 7'd1 || instr_count !== 32'd1 || cycle_count !== 32'd1) begin
      failures++;
      $display("FAIL compact_counts: count=%0d instr=%0d cyc=%0d, expected 1/1/1",
               trace_count, instr_count, cycle_count);
    end
    checks++;
    if (rd_pc !== 32'h40) begin
      failures++;
      $display("FAIL compact_head_pc: got %h expected 00000040", rd_pc);
    end
    drain_and_check("compact");
  endtask

  task automatic fill63();
    for (int k = 0; k < 31; k++) drive(2'b11, 32'h1000 + 32'(8 * k), 1'b1);
    drive(2'b01, 32'h1000 + 32'(8 * 31), 1'b1);
    tick();
    checks++;
    if (trace_count !== 7'd63 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fill63: count=%0d ovf=%b, expected 63/0", trace_count, overflow);
    end
  endtask

  task automatic test_full_freeze();
    do_clear(); wrap_mode = 1'b0;
    do_arm();
    fill63();
    drive(2'b11, 32'h2000, 1'b1);
    tick();
    checks++;
    if (trace_count !== 7'd64 || overflow !== 1'b1 || instr_count !== 32'd65) begin
      failures++;
      $display("FAIL freeze_full: count=%0d ovf=%b instr=%0d, expected 64/1/65",
               trace_count, overflow, instr_count);
    end
    drain_and_check("freeze");
  endtask

  task automatic test_full_wrap();
    do_clear(); wrap_mode = 1'b1;
    do_arm();
    fill63();
    drive(2'b11, 32'h2000, 1'b1);
    tick();
    checks++;
    if (trace_count !== 7'd64 || overflow !== 1'b1 || rd_pc !== 32'h1004) begin
      failures++;
      $display("FAIL wrap_full: count=%0d ovf=%b head=%h, expected 64/1/00001004",
               trace_count, overflow, rd_pc);
    end
    drain_and_check("wrap");
    wrap_mode = 1'b0;
  endtask

  task automatic test_core_err();
    do_clear(); wrap_mode = 1'b0;
    do_arm();
    drive(2'b11, 32'h3000, 1'b1);
    drive(2'b01, 32'h3010, 1'b1);
    error_status = HALTED_ON_WFI;
    drive(2'b10, 32'h3020, 1'b1);
    error_status = NO_ERROR;
    drive(2'b11, 32'h3030, 1'b0);
    checks++;
    if (halted !== 1'b1 || halt_cause !== 2'd1) begin
      failures++;
      $display("FAIL core_err_halt: halted=%b cause=%0d, expected 1/1", halted, halt_cause);
    end
    drive(2'b11, 32'h3040, 1'b0);
    tick();
    checks++;
    if (instr_count !== 32'd4 || cycle_count !== 32'd3 || trace_count !== 7'd4) begin
      failures++;
      $display("FAIL core_err_frozen: instr=%0d cyc=%0d count=%0d, expected 4/3/4",
               instr_count, cycle_count, trace_count);
    end
    do_arm();
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL halted_ignores_arm: halted=%b expected 1", halted);
    end
    drain_and_check("core_err");
  endtask

  task automatic test_watchdog();
    do_clear();
    do_arm();
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (halted !== 1'b0) begin
      failures++;
      $display("FAIL wdog_early: halted=%b expected 0 after 7 idle cycles", halted);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || halt_cause !== 2'd2 || cycle_count !== 32'd8) begin
      failures++;
      $display("FAIL wdog_halt: halted=%b cause=%0d cyc=%0d, expected 1/2/8",
               halted, halt_cause, cycle_count);
    end
  endtask

  task automatic test_clear_arm();
    clear = 1'b1; arm = 1'b1;
    tick();
    clear = 1'b0; arm = 1'b0;
    q.delete();
    checks++;
    if (halted !== 1'b0 || halt_cause !== 2'd0 || cycle_count !== 32'd0 || trace_count !== 7'd0) begin
      failures++;
      $display("FAIL clear_arm_flags: halted=%b cause=%0d cyc=%0d count=%0d, expected 0",
               halted, halt_cause, cycle_count, trace_count);
    end
    for (int k = 0; k < 3; k++) drive(2'b11, 32'h5000 + 32'(8 * k), 1'b0);
    tick();
    checks++;
    if (trace_count !== 7'd0 || cycle_count !== 32'd0 || instr_count !== 32'd0) begin
      failures++;
      $display("FAIL clear_arm_idle: count=%0d cyc=%0d instr=%0d, expected 0/0/0",
               trace_count, cycle_count, instr_count);
    end
  endtask

  task automatic test_load_fault();
    do_clear();
    do_arm();
    error_status = LOAD_ACCESS_FAULT;
    for (int k = 0; k < 12; k++) drive(2'b01, 32'h6000 + 32'(8 * k), 1'b1);
    error_status = NO_ERROR;
    tick();
    checks++;
    if (halted !== 1'b0 || halt_cause !== 2'd0 || trace_count !== 7'd12) begin
      failures++;
      $display("FAIL load_fault: halted=%b cause=%0d count=%0d, expected 0/0/12",
               halted, halt_cause, trace_count);
    end
    drain_and_check("load_fault");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_clear(); wrap_mode = 1'b0;
    do_arm();
    rd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (rd_valid) begin
        e = q.pop_front();
        checks++;
        if (rd_pc !== e.pc || rd_data !== e.data || rd_arn !== e.arn) begin
          failures++;
          $display("FAIL b2b_entry: got pc=%h data=%h, expected pc=%h data=%h",
                   rd_pc, rd_data, e.pc, e.data);
        end
      end
      drive(2'b11, 32'h7000 + 32'(8 * k), 1'b1);
    end
    drain_and_check("b2b");
    checks++;
    if (instr_count !== 32'd20) begin
      failures++;
      $display("FAIL b2b_instr: got %0d expected 20", instr_count);
    end
  endtask

  task automatic test_reset_mid();
    do_clear();
    do_arm();
    for (int k = 0; k < 5; k++) drive(2'b11, 32'h8000 + 32'(8 * k), 1'b0);
    tick();
    checks++;
    if (trace_count !== 7'd10) begin
      failures++;
      $display("FAIL reset_mid_fill: count=%0d expected 10", trace_count);
    end
    #2 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (trace_count !== 7'd0 || rd_valid !== 1'b0 || cycle_count !== 32'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: count=%0d rd_valid=%b cyc=%0d halted=%b, expected 0",
               trace_count, rd_valid, cycle_count, halted);
    end
    reset = 1'b1;
    tick();
    drive(2'b11, 32'h9000, 1'b0);
    tick();
    checks++;
    if (trace_count !== 7'd0 || cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_idle: count=%0d cyc=%0d, expected 0/0", trace_count, cycle_count);
    end
  endtask

  initial begin
    commit_valid = '0; commit_pc = '0; commit_arn = '0; commit_data = '0; commit_wr_en = '0;
    error_status = NO_ERROR; arm = 1'b0; clear = 1'b0; wrap_mode = 1'b0; rd_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_compaction();
    test_full_freeze();
    test_full_wrap();
    test_core_err();
    test_watchdog();
    test_clear_arm();
    test_load_fault();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
